// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
//   Loads a program image received word by word into instruction memory and
//   holds the CPU in reset until the image has been verified.
//
//   Image format: header word {16'hB007, N}, then N payload words, then one
//   checksum word equal to the modulo-2**32 sum of the payload.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   boot_req   level request to load a new program image
//   word_vld   one-cycle strobe, word is valid
//   word       received 32-bit word
//   dbg_en     enables the word receiver while a load is in progress
//   imem_we    instruction-memory write enable
//   imem_addr  instruction-memory word address
//   imem_wdata instruction-memory write data
//   cpu_rst    holds the CPU in reset when 1
//   busy       load in progress
//   done       last load passed its checksum (sticky)
//   err        load failed (sticky until the next load starts)
//   err_code   0 none, 1 bad header, 2 checksum, 3 timeout, 4 abort
// -----------------------------------------------------------------------------
module boot_sequencer #(
    parameter int unsigned ADDR_W      = 32'd13,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_req,
    input  logic              word_vld,
    input  logic [31:0]       word,
    output logic              dbg_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_HEADER  = 3'd1;
    localparam logic [2:0] ERR_CHKSUM  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_ABORT   = 3'd4;

    // Header: magic in the upper half, payload length 1..2**ADDR_W in the lower.
    // 17-bit length arithmetic so that 2**16 is representable for ADDR_W=16.
    function automatic logic header_ok(input logic [31:0] w);
        logic [16:0] len;
        len = {1'b0, w[15:0]};
        return (w[31:16] == 16'hB007) && (len != 17'd0) &&
               (len <= (17'd1 << ADDR_W));
    endfunction

    function automatic logic is_loading(input state_t s);
        return (s == ST_HEADER) || (s == ST_LOAD) || (s == ST_CHECK);
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic                boot_req_q_r;
    logic                boot_rise_s;
    logic                tmo_hit_s;

    logic [16:0]         idx_r,   idx_nxt_s;
    logic [16:0]         len_r,   len_nxt_s;
    logic [31:0]         acc_r,   acc_nxt_s;
    logic [23:0]         tmo_r,   tmo_nxt_s;

    logic                dbg_en_r;
    logic                imem_we_r,    we_nxt_s;
    logic [ADDR_W-1:0]   imem_addr_r,  addr_nxt_s;
    logic [31:0]         imem_wdata_r, wdata_nxt_s;
    logic                cpu_rst_r;
    logic                busy_r;
    logic                done_r,       done_nxt_s;
    logic                err_r;
    logic [2:0]          err_code_r,   code_nxt_s;

    assign boot_rise_s = boot_req & ~boot_req_q_r;
    assign tmo_hit_s   = (tmo_r == (TIMEOUT_CYC - 24'd1));

    // Next-state and next-value logic for the whole sequencer.
    always_comb begin
        next_state_s = state_r;
        idx_nxt_s    = idx_r;
        len_nxt_s    = len_r;
        acc_nxt_s    = acc_r;
        tmo_nxt_s    = 24'd0;
        we_nxt_s     = 1'b0;
        addr_nxt_s   = imem_addr_r;
        wdata_nxt_s  = imem_wdata_r;
        done_nxt_s   = done_r;
        code_nxt_s   = err_code_r;

        case (state_r)
            ST_IDLE: begin
                if (boot_req) begin
                    next_state_s = ST_HEADER;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HEADER: begin
                // Abort outranks any word or timeout in the same cycle.
                if (!boot_req) begin
                    next_state_s = ST_ERROR;
                    code_nxt_s   = ERR_ABORT;
                end else if (word_vld) begin
                    if (header_ok(word)) begin
                        next_state_s = ST_LOAD;
                        len_nxt_s    = {1'b0, word[15:0]};
                    end else begin
                        next_state_s = ST_ERROR;
                        code_nxt_s   = ERR_HEADER;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                    code_nxt_s   = ERR_TIMEOUT;
                end else begin
                    next_state_s = ST_HEADER;
                end
            end
            ST_LOAD: begin
                if (!boot_req) begin
                    next_state_s = ST_ERROR;
                    code_nxt_s   = ERR_ABORT;
                end else if (word_vld) begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = idx_r[ADDR_W-1:0];
                    wdata_nxt_s = word;
                    acc_nxt_s   = acc_r + word;
                    idx_nxt_s   = idx_r + 17'd1;
                    if ((idx_r + 17'd1) == len_r) begin
                        next_state_s = ST_CHECK;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                    code_nxt_s   = ERR_TIMEOUT;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (!boot_req) begin
                    next_state_s = ST_ERROR;
                    code_nxt_s   = ERR_ABORT;
                end else if (word_vld) begin
                    if (word == acc_r) begin
                        next_state_s = ST_RUN;
                        done_nxt_s   = 1'b1;
                    end else begin
                        next_state_s = ST_ERROR;
                        code_nxt_s   = ERR_CHKSUM;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                    code_nxt_s   = ERR_TIMEOUT;
                end else begin
                    next_state_s = ST_CHECK;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (boot_rise_s) begin
                    next_state_s = ST_HEADER;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase

        // Starting a new load wipes the previous result and the load context.
        if ((next_state_s == ST_HEADER) && (state_r != ST_HEADER)) begin
            done_nxt_s = 1'b0;
            code_nxt_s = ERR_NONE;
            idx_nxt_s  = 17'd0;
            acc_nxt_s  = 32'd0;
        end else begin
            done_nxt_s = done_nxt_s;
        end

        // Idle-gap counter: restarts on any state change or received word.
        if ((next_state_s != state_r) || word_vld) begin
            tmo_nxt_s = 24'd0;
        end else if (is_loading(state_r)) begin
            tmo_nxt_s = tmo_r + 24'd1;
        end else begin
            tmo_nxt_s = 24'd0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Load context and registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_req_q_r <= 1'b0;
            idx_r        <= 17'd0;
            len_r        <= 17'd0;
            acc_r        <= 32'd0;
            tmo_r        <= 24'd0;
            dbg_en_r     <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            cpu_rst_r    <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
        end else begin
            boot_req_q_r <= boot_req;
            idx_r        <= idx_nxt_s;
            len_r        <= len_nxt_s;
            acc_r        <= acc_nxt_s;
            tmo_r        <= tmo_nxt_s;
            dbg_en_r     <= is_loading(next_state_s);
            imem_we_r    <= we_nxt_s;
            imem_addr_r  <= addr_nxt_s;
            imem_wdata_r <= wdata_nxt_s;
            cpu_rst_r    <= (next_state_s != ST_RUN);
            busy_r       <= is_loading(next_state_s);
            done_r       <= done_nxt_s;
            err_r        <= (next_state_s == ST_ERROR);
            err_code_r   <= code_nxt_s;
        end
    end

    assign dbg_en     = dbg_en_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_boot_sequencer
//   Directed stimulus for boot_sequencer. A behavioural image-loader model
//   predicts every output after each clock edge; a compare process checks the
//   DUT against it on every falling edge. Literal expectations inside the
//   stimulus pin the model itself.
// -----------------------------------------------------------------------------
module tb_boot_sequencer;

    localparam int ADDR_W = 13;
    localparam int TMO    = 100;

    localparam int P_IDLE = 0;
    localparam int P_HDR  = 1;
    localparam int P_LOAD = 2;
    localparam int P_CHK  = 3;
    localparam int P_RUN  = 4;
    localparam int P_ERR  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              boot_req = 1'b0;
    logic              word_vld = 1'b0;
    logic [31:0]       word = 32'd0;
    logic              dbg_en;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        err_code;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model of the loader
    int                m_phase = P_IDLE;
    int                m_cnt = 0;
    int                m_len = 0;
    logic [31:0]       m_sum = 32'd0;
    int                m_quiet = 0;
    logic              m_br_prev = 1'b0;
    logic              e_we = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [31:0]       e_wdata = 32'd0;
    logic              e_done = 1'b0;
    logic [2:0]        e_code = 3'd0;

    boot_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(24'd100)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_req   (boot_req),
        .word_vld   (word_vld),
        .word       (word),
        .dbg_en     (dbg_en),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the loader model by one clock edge with the given inputs.
    task automatic model_step(input logic r, input logic br, input logic vld,
                              input logic [31:0] w);
        int nxt;
        int len;
        nxt  = m_phase;
        e_we = 1'b0;
        if (r) begin
            m_phase = P_IDLE; m_cnt = 0; m_len = 0; m_sum = 32'd0; m_quiet = 0;
            m_br_prev = 1'b0; e_addr = '0; e_wdata = 32'd0; e_done = 1'b0;
            e_code = 3'd0;
            return;
        end
        if (m_phase == P_IDLE) begin
            nxt = br ? P_HDR : P_RUN;
        end else if (m_phase == P_RUN || m_phase == P_ERR) begin
            if (br && !m_br_prev) nxt = P_HDR;
        end else if (!br) begin
            nxt = P_ERR; e_code = 3'd4;
        end else if (vld) begin
            if (m_phase == P_HDR) begin
                len = int'(w[15:0]);
                if (w[31:16] == 16'hB007 && len >= 1 && len <= (1 << ADDR_W)) begin
                    m_len = len; nxt = P_LOAD;
                end else begin
                    nxt = P_ERR; e_code = 3'd1;
                end
            end else if (m_phase == P_LOAD) begin
                e_we    = 1'b1;
                e_addr  = ADDR_W'(m_cnt);
                e_wdata = w;
                m_sum   = m_sum + w;
                m_cnt++;
                if (m_cnt == m_len) nxt = P_CHK;
            end else begin
                if (w == m_sum) begin
                    nxt = P_RUN; e_done = 1'b1;
                end else begin
                    nxt = P_ERR; e_code = 3'd2;
                end
            end
        end else if (m_quiet + 1 >= TMO) begin
            nxt = P_ERR; e_code = 3'd3;
        end
        if (nxt == P_HDR && m_phase != P_HDR) begin
            e_done = 1'b0; e_code = 3'd0; m_cnt = 0; m_sum = 32'd0;
        end
        if (vld || nxt != m_phase || !(nxt == P_HDR || nxt == P_LOAD || nxt == P_CHK))
            m_quiet = 0;
        else
            m_quiet++;
        m_br_prev = br;
        m_phase   = nxt;
    endtask

    // One clock cycle: drive inputs, take the edge, update the model.
    task automatic cyc(input logic r, input logic br, input logic vld,
                       input logic [31:0] w);
        rst = r; boot_req = br; word_vld = vld; word = w;
        @(posedge clk);
        model_step(r, br, vld, w);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        cyc(1'b0, 1'b1, 1'b1, w);
    endtask

    // Drop then raise boot_req from RUN/ERROR to start a new load.
    task automatic rearm();
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dbg_en",     32'(dbg_en),     32'(m_phase == P_HDR || m_phase == P_LOAD || m_phase == P_CHK));
            check("busy",       32'(busy),       32'(m_phase == P_HDR || m_phase == P_LOAD || m_phase == P_CHK));
            check("cpu_rst",    32'(cpu_rst),    32'(m_phase != P_RUN));
            check("err",        32'(err),        32'(m_phase == P_ERR));
            check("err_code",   32'(err_code),   32'(e_code));
            check("done",       32'(done),       32'(e_done));
            check("imem_we",    32'(imem_we),    32'(e_we));
            check("imem_addr",  32'(imem_addr),  32'(e_addr));
            check("imem_wdata", imem_wdata,      e_wdata);
        end
    end

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_addr",    32'(imem_addr), 32'd0);

        // Release with boot_req low: IDLE one cycle, then RUN
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);

        // Good image of three words
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("hdr_busy", 32'(busy), 32'd1);
        send(32'hB007_0003);
        send(32'h11);
        check("w0", {31'(imem_addr), imem_we}, {31'd0, 1'b1});
        check("w0_data", imem_wdata, 32'h11);
        send(32'h22);
        check("w1_addr", 32'(imem_addr), 32'd1);
        send(32'h33);
        check("w2_addr", 32'(imem_addr), 32'd2);
        check("w2_data", imem_wdata, 32'h33);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("hold_we",   32'(imem_we), 32'd0);
        check("hold_data", imem_wdata, 32'h33);
        send(32'h66);
        check("good_done", {29'd0, done, cpu_rst, err}, {29'd0, 1'b1, 1'b0, 1'b0});

        // Bad checksum, then a wrapping-sum image recovers
        rearm();
        check("clr_done", 32'(done), 32'd0);
        send(32'hB007_0003); send(32'h11); send(32'h22); send(32'h33);
        send(32'h67);
        check("cks_code", 32'(err_code), 32'd2);
        check("cks_cpu",  {30'd0, err, cpu_rst}, {30'd0, 1'b1, 1'b1});
        send(32'h1234);
        check("err_ignore_vld", 32'(imem_we), 32'd0);
        rearm();
        check("clr_err", {29'd0, err, err_code[1:0]}, 32'd0);
        send(32'hB007_0002); send(32'h5); send(32'hFFFF_FFFF);
        send(32'h0000_0004);
        check("wrap_done", 32'(done), 32'd1);

        // Header errors and the length boundary
        rearm();
        send(32'hDEAD_0003);
        check("bad_magic", {28'd0, imem_we, err_code}, 32'd1);
        rearm();
        send(32'hB007_0000);
        check("len_zero", 32'(err_code), 32'd1);
        rearm();
        send(32'hB007_2000);
        check("len_max", {30'd0, busy, err}, 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        check("abort_hdr", 32'(err_code), 32'd4);
        rearm();
        send(32'hB007_2001);
        check("len_over", 32'(err_code), 32'd1);

        // Abort after two payload words, coinciding with a strobe
        rearm();
        send(32'hB007_0004); send(32'h1); send(32'h2);
        cyc(1'b0, 1'b0, 1'b1, 32'h3);
        check("abort_code", {28'd0, imem_we, err_code}, 32'd4);

        // Timeout 100 cycles after the header strobe
        rearm();
        send(32'hB007_0005);
        for (int i = 0; i < 99; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("tmo_early", {30'd0, busy, err}, 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("tmo_code", 32'(err_code), 32'd3);

        // Reset in the middle of a load
        rearm();
        send(32'hB007_0003); send(32'hA);
        cyc(1'b1, 1'b1, 1'b1, 32'hB);
        check("mid_rst", {imem_we, busy, err, done, cpu_rst, err_code},
              {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        check("mid_rst_bus", imem_wdata | 32'(imem_addr), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        check("post_rst_hdr", 32'(busy), 32'd1);
        send(32'hB007_0001); send(32'h7); send(32'h7);
        check("final_done", 32'(done), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
